// File: rtl/noc_traffic_gen.sv
// Multi-port 2-phase (toggle) packet generator feeding the upstream ports of the async switch.
// Each port runs IDLE -> GAP -> LOAD -> SEND; a shared LFSR randomises inter-flit gaps in concurrent mode.
module noc_traffic_gen #(
  parameter int          NUM_PORTS   = 5,
  parameter int          WORD_WIDTH  = 32,
  parameter int          FLITS       = 20,
  parameter int          PACKETS     = 40,
  parameter int          GAP_CYCLES  = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            gen_enable,
  input  logic                            mode,
  output logic [NUM_PORTS-1:0]            req_o,
  output logic [NUM_PORTS*WORD_WIDTH-1:0] data_o,
  input  logic [NUM_PORTS-1:0]            ack_i,
  output logic [NUM_PORTS*16-1:0]         pkt_count_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int          DW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int          GW      = $clog2(GAP_CYCLES + 16);
  localparam logic [15:0] PKTS    = 16'(PACKETS);
  localparam logic [15:0] LAST    = 16'(FLITS - 1);
  localparam logic [GW-1:0] GAP_MIN = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, GAP, LOAD, SEND} state_e;

  state_e                state_q [NUM_PORTS];
  state_e                state_d [NUM_PORTS];
  logic [GW-1:0]         gap_q   [NUM_PORTS];
  logic [GW-1:0]         gap_d   [NUM_PORTS];
  logic [15:0]           count_q [NUM_PORTS];
  logic [15:0]           count_d [NUM_PORTS];
  logic [15:0]           fidx_q  [NUM_PORTS];
  logic [15:0]           fidx_d  [NUM_PORTS];
  logic [WORD_WIDTH-1:0] data_q  [NUM_PORTS];
  logic [WORD_WIDTH-1:0] data_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  sync_q  [SYNC_STAGES];
  logic [NUM_PORTS-1:0]  req_q, req_d, ack_s, busy_vec;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  mode_q, mode_d, done_q, done_d;

  function automatic logic [WORD_WIDTH-1:0] make_flit(input int p, input logic [15:0] cnt,
                                                      input logic [15:0] idx);
    logic [WORD_WIDTH-1:0] f;
    int dest;
    f = '0;
    f[WORD_WIDTH-1 -: 8] = p[7:0];
    f[WORD_WIDTH-9 -: 8] = cnt[7:0];
    if (idx == 16'd0) begin
      dest = (p + 1 + int'(cnt)) % NUM_PORTS;
      f[2 +: DW] = dest[DW-1:0];
      f[1:0] = 2'b01;
    end else begin
      f[WORD_WIDTH-17 -: 8] = idx[7:0];
      f[1:0] = (idx == LAST) ? 2'b10 : 2'b00;
    end
    return f;
  endfunction

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_comb begin : next_state
    int rank;
    logic [3:0] nib;
    logic [GW-1:0] gap_entry;
    logic eff_mode, prev_full, all_full, start;
    lfsr_d    = gen_enable ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                           : lfsr_q;
    // Mode is only taken from the pin while every port is idle.
    eff_mode  = (|busy_vec) ? mode_q : mode;
    mode_d    = eff_mode;
    rank      = 0;
    prev_full = 1'b1;
    all_full  = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      gap_d[p]   = gap_q[p];
      count_d[p] = count_q[p];
      fidx_d[p]  = fidx_q[p];
      data_d[p]  = data_q[p];
      req_d[p]   = req_q[p];
      start      = eff_mode | prev_full;
      // Simultaneous GAP entries each see the LFSR shifted by their rank, lowest port first.
      nib        = 4'(lfsr_q >> rank);
      gap_entry  = eff_mode ? (GAP_MIN + GW'(nib)) : GAP_MIN;
      case (state_q[p])
        IDLE: begin
          if (start && gen_enable && (count_q[p] < PKTS)) begin
            state_d[p] = GAP;
            gap_d[p]   = gap_entry;
            rank       = rank + 1;
          end
        end
        GAP: begin
          if (gap_q[p] <= GW'(1)) begin
            state_d[p] = LOAD;
            data_d[p]  = make_flit(p, count_q[p], fidx_q[p]);
          end else begin
            gap_d[p] = gap_q[p] - GW'(1);
          end
        end
        LOAD: begin
          state_d[p] = SEND;
          req_d[p]   = ~req_q[p];
        end
        SEND: begin
          if (ack_s[p] == req_q[p]) begin
            if (fidx_q[p] == LAST) begin
              count_d[p] = count_q[p] + 16'd1;
              fidx_d[p]  = '0;
              if ((count_q[p] + 16'd1 == PKTS) || !gen_enable) begin
                state_d[p] = IDLE;
              end else begin
                state_d[p] = GAP;
                gap_d[p]   = gap_entry;
                rank       = rank + 1;
              end
            end else begin
              fidx_d[p]  = fidx_q[p] + 16'd1;
              state_d[p] = GAP;
              gap_d[p]   = gap_entry;
              rank       = rank + 1;
            end
          end
        end
        default: state_d[p] = IDLE;
      endcase
      all_full  = all_full & (count_d[p] == PKTS);
      prev_full = (count_q[p] == PKTS);
    end
    done_d = done_q | all_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= IDLE;
        gap_q[p]   <= '0;
        count_q[p] <= '0;
        fidx_q[p]  <= '0;
        data_q[p]  <= '0;
      end
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      req_q  <= '0;
      lfsr_q <= LFSR_SEED;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= state_d[p];
        gap_q[p]   <= gap_d[p];
        count_q[p] <= count_d[p];
        fidx_q[p]  <= fidx_d[p];
        data_q[p]  <= data_d[p];
      end
      sync_q[0] <= ack_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      req_q  <= req_d;
      lfsr_q <= lfsr_d;
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign data_o[g*WORD_WIDTH +: WORD_WIDTH] = data_q[g];
    assign pkt_count_o[g*16 +: 16]            = count_q[g];
    assign busy_vec[g]                        = (state_q[g] != IDLE);
  end

  assign req_o  = req_q;
  assign busy_o = |busy_vec;
  assign done_o = done_q;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Scoreboard bench for noc_traffic_gen: ack loopback through a 3-cycle delay, expected flit
// streams generated per port from the packet format rules, toggles checked by a negedge monitor.
module tb_noc_traffic_gen;
  localparam int NP = 5, WW = 32, FL = 10, PK = 6, GAPC = 3, SS = 2;

  logic clk = 1'b0, reset = 1'b1, gen_enable = 1'b0, mode = 1'b0;
  logic [NP-1:0]    req_o, ack_i;
  logic [NP*WW-1:0] data_o;
  logic [NP*16-1:0] pkt_count_o;
  logic             busy_o, done_o;

  logic [NP-1:0] dly0 = '0, dly1 = '0, dly2 = '0;
  logic          loop_en = 1'b0;
  logic [NP-1:0] ack_man = '0, hold_mask = '0, ack_hold = '0;

  int checks = 0, errors = 0;
  int cyc = 0, d0 = -1, gap_mode = 0;
  bit seq_chk = 1'b0;
  logic [15:0] gap_seen = '0;
  logic [WW-1:0] exp_q [NP][$];
  int tgl_cnt [NP];
  int last_t  [NP];
  int first_t [NP];
  logic [WW-1:0] prev_data [NP];
  logic [NP-1:0] prev_req = '0;
  logic          prev_done = 1'b0;

  noc_traffic_gen #(.NUM_PORTS(NP), .WORD_WIDTH(WW), .FLITS(FL), .PACKETS(PK),
                    .GAP_CYCLES(GAPC), .SYNC_STAGES(SS), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .gen_enable(gen_enable), .mode(mode), .req_o(req_o),
    .data_o(data_o), .ack_i(ack_i), .pkt_count_o(pkt_count_o), .busy_o(busy_o), .done_o(done_o));

  always #5 clk = ~clk;

  assign ack_i = loop_en ? ((dly2 & ~hold_mask) | (ack_hold & hold_mask)) : ack_man;

  always @(posedge clk) begin
    dly0 <= req_o;
    dly1 <= dly0;
    dly2 <= dly1;
    cyc  <= cyc + 1;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] ref_flit(input int p, input int c, input int i);
    int v;
    v = (p << 24) | ((c % 256) << 16);
    if (i == 0) v = v | (((p + 1 + c) % NP) << 2) | 1;
    else        v = v | ((i % 256) << 8) | ((i == FL - 1) ? 2 : 0);
    return WW'(v);
  endfunction

  function automatic int n_full();
    int n = 0;
    for (int p = 0; p < NP; p++) if (pkt_count_o[p*16 +: 16] == 16'(PK)) n++;
    return n;
  endfunction

  task automatic push_all();
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < PK; c++)
        for (int i = 0; i < FL; i++) exp_q[p].push_back(ref_flit(p, c, i));
  endtask

  task automatic clear_sb();
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      tgl_cnt[p] = 0;
      first_t[p] = -1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    reset = 1'b1;
    gen_enable = 1'b0;
    repeat (5) @(posedge clk);
    clear_sb();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done_o && n < budget) begin @(negedge clk); n++; end
    chk(done_o == 1'b1, name, n, budget);
  endtask

  task automatic check_run_complete(input string name);
    chk(n_full() == NP, {name, "_counts"}, n_full(), NP);
    for (int p = 0; p < NP; p++) chk(exp_q[p].size() == 0, {name, "_sb_left"}, exp_q[p].size(), 0);
    @(negedge clk);
    chk(busy_o == 1'b0, {name, "_busy_end"}, busy_o, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(req_o == '0, {name, "_req"}, req_o, 0);
    chk(data_o == '0, {name, "_data"}, data_o[63:0], 0);
    chk(pkt_count_o == '0, {name, "_count"}, pkt_count_o[63:0], 0);
    chk(done_o == 1'b0 && busy_o == 1'b0, {name, "_done_busy"}, {done_o, busy_o}, 0);
  endtask

  // Scoreboard monitor: every req toggle pops one expected flit for that port.
  always @(negedge clk) begin : mon
    logic [WW-1:0] cur, expv;
    int d;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        last_t[p]    = -1;
        prev_data[p] = data_o[p*WW +: WW];
      end
      prev_req  = req_o;
      prev_done = done_o;
    end else begin
      for (int p = 0; p < NP; p++) begin
        cur = data_o[p*WW +: WW];
        if (req_o[p] != prev_req[p]) begin
          tgl_cnt[p]++;
          if (tgl_cnt[p] == 1) first_t[p] = cyc;
          chk(cur == prev_data[p], "bundle_setup", cur, prev_data[p]);
          if (exp_q[p].size() == 0) chk(1'b0, "sb_empty", cur, 0);
          else begin
            expv = exp_q[p].pop_front();
            chk(cur == expv, $sformatf("flit_p%0d", p), cur, expv);
          end
          if (seq_chk && p > 0 && tgl_cnt[p] == 1)
            chk(tgl_cnt[(p + NP - 1) % NP] == PK * FL, "seq_order", tgl_cnt[(p + NP - 1) % NP], PK * FL);
          if (last_t[p] >= 0) begin
            d = cyc - last_t[p];
            if (gap_mode == 1) begin
              if (d0 < 0) d0 = d;
              else chk(d == d0, "gap_seq", d, d0);
            end else if (gap_mode == 2) begin
              chk(d >= d0 && d <= d0 + 15, "gap_rand", d, d0);
              if (d >= d0 && d <= d0 + 15) gap_seen[d - d0] = 1'b1;
            end
          end
          last_t[p] = cyc;
        end else if (req_o[p] != ack_i[p]) begin
          chk(cur == prev_data[p], "hold_data", cur, prev_data[p]);
        end
        prev_data[p] = cur;
      end
      if (done_o && !prev_done) chk(n_full() == NP, "done_counts", n_full(), NP);
      chk(!(prev_done && !done_o), "done_sticky", done_o, prev_done);
      prev_req  = req_o;
      prev_done = done_o;
    end
  end

  initial begin : stim
    int n, c0, mn, mx;
    clear_sb();
    for (int p = 0; p < NP; p++) last_t[p] = -1;

    // Reset with random ack activity, then idle with gen_enable low.
    for (int i = 0; i < 5; i++) begin @(posedge clk); ack_man = NP'($urandom); end
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    reset = 1'b0;
    repeat (10) begin @(posedge clk); ack_man = NP'($urandom); end
    @(negedge clk);
    check_reset_outputs("ack_ignored");

    // Sequential run.
    loop_en = 1'b1;
    do_reset();
    push_all();
    gap_mode = 1; seq_chk = 1'b1;
    @(negedge clk);
    c0 = cyc; mode = 1'b0; gen_enable = 1'b1;
    wait_done(6000, "seq_done");
    chk(first_t[0] - c0 == GAPC + 2, "start_latency", first_t[0] - c0, GAPC + 2);
    check_run_complete("seq");

    // Concurrent randomised run.
    do_reset();
    push_all();
    gap_mode = 2; seq_chk = 1'b0; gap_seen = '0;
    @(negedge clk);
    mode = 1'b1; gen_enable = 1'b1;
    wait_done(4000, "conc_done");
    mn = first_t[0]; mx = first_t[0];
    for (int p = 1; p < NP; p++) begin
      if (first_t[p] < mn) mn = first_t[p];
      if (first_t[p] > mx) mx = first_t[p];
    end
    chk(mn >= 0 && mx - mn <= 15, "conc_start_spread", mx - mn, 15);
    chk($countones(gap_seen) > 1, "gap_variety", $countones(gap_seen), 2);
    check_run_complete("conc");

    // Pause mid-packet: the packet completes, then the port idles.
    do_reset();
    push_all();
    gap_mode = 0;
    @(negedge clk);
    mode = 1'b0; gen_enable = 1'b1;
    n = 0;
    while (tgl_cnt[0] < 3 * FL + 8 && n < 2000) begin @(negedge clk); n++; end
    chk(tgl_cnt[0] == 3 * FL + 8, "drop_reach", tgl_cnt[0], 3 * FL + 8);
    gen_enable = 1'b0;
    n = 0;
    while ((busy_o || tgl_cnt[0] < 4 * FL) && n < 500) begin @(negedge clk); n++; end
    chk(tgl_cnt[0] == 4 * FL, "drop_flits", tgl_cnt[0], 4 * FL);
    chk(pkt_count_o[15:0] == 16'd4, "drop_count", pkt_count_o[15:0], 4);
    repeat (30) @(negedge clk);
    chk(busy_o == 1'b0 && tgl_cnt[0] == 4 * FL && tgl_cnt[1] == 0, "drop_idle", tgl_cnt[0], 4 * FL);
    c0 = cyc; gen_enable = 1'b1;
    n = 0;
    while (tgl_cnt[0] < 4 * FL + 1 && n < 100) begin @(negedge clk); n++; end
    chk(last_t[0] - c0 == GAPC + 2, "resume_latency", last_t[0] - c0, GAPC + 2);
    wait_done(6000, "drop_done");
    check_run_complete("drop");

    // Port 2 ack frozen: port 2 stalls, the rest finish.
    hold_mask = NP'(5'b00100); ack_hold = '0;
    do_reset();
    push_all();
    gap_mode = 2;
    @(negedge clk);
    mode = 1'b1; gen_enable = 1'b1;
    n = 0;
    while (n_full() < NP - 1 && n < 4000) begin @(negedge clk); n++; end
    repeat (50) @(negedge clk);
    chk(n_full() == NP - 1, "stall_others_full", n_full(), NP - 1);
    chk(tgl_cnt[2] == 1, "stall_toggles", tgl_cnt[2], 1);
    chk(pkt_count_o[2*16 +: 16] == 16'd0, "stall_count", pkt_count_o[2*16 +: 16], 0);
    chk(req_o[2] == 1'b1 && busy_o == 1'b1 && done_o == 1'b0, "stall_state",
        {req_o[2], busy_o, done_o}, 3'b110);
    chk(data_o[2*WW +: WW] == ref_flit(2, 0, 0), "stall_data", data_o[2*WW +: WW], ref_flit(2, 0, 0));

    // All ports parked in SEND, then reset mid-flit and rerun.
    hold_mask = '1;
    do_reset();
    push_all();
    @(negedge clk);
    mode = 1'b1; gen_enable = 1'b1;
    n = 0;
    while (req_o != '1 && n < 100) begin @(negedge clk); n++; end
    chk(req_o == '1 && busy_o == 1'b1, "all_in_send", req_o, 5'h1f);
    @(posedge clk);
    reset = 1'b1;
    gen_enable = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_send_reset");
    repeat (4) @(posedge clk);
    hold_mask = '0;
    clear_sb();
    reset = 1'b0;
    push_all();
    @(negedge clk);
    gen_enable = 1'b1;
    wait_done(4000, "rerun_done");
    check_run_complete("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
